// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic
//   Elastic pipeline-stage register carrying PC, instruction, A3, BD, ExcCode
//   and NLANES data lanes under a valid/ready handshake. SKID=1 adds a
//   one-entry skid buffer so in_ready is registered (no comb path from
//   out_ready) while keeping full throughput. req redirects to HANDLER_PC,
//   flush inserts a bubble; both drop the stage contents and the offered beat.
//   Two saturating perf counters track stall and kill cycles.
// Ports
//   clk, reset            clock, synchronous active-low reset
//   req, flush            exception redirect / bubble insert (req wins)
//   in_valid, in_ready    upstream handshake
//   in_*                  upstream payload (pc, instr, a3, bd, exc, lanes)
//   out_valid, out_ready  downstream handshake
//   out_*                 registered payload
//   cnt_clr               synchronous clear of both counters
//   stall_cnt, kill_cnt   saturating counters (CW bits)
module pipe_stage_elastic #(
    parameter int          DW         = 32,
    parameter int          NLANES     = 3,
    parameter int          SKID       = 1,
    parameter logic [31:0] RESET_PC   = 32'h3000,
    parameter logic [31:0] HANDLER_PC = 32'h4180,
    parameter int          CW         = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_pc,
    input  logic [31:0]          in_instr,
    input  logic [4:0]           in_a3,
    input  logic                 in_bd,
    input  logic [4:0]           in_exc,
    input  logic [NLANES*DW-1:0] in_lanes,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_pc,
    output logic [31:0]          out_instr,
    output logic [4:0]           out_a3,
    output logic                 out_bd,
    output logic [4:0]           out_exc,
    output logic [NLANES*DW-1:0] out_lanes,
    input  logic                 cnt_clr,
    output logic [CW-1:0]        stall_cnt,
    output logic [CW-1:0]        kill_cnt
);

    typedef struct packed {
        logic [31:0]          pc;
        logic [31:0]          instr;
        logic [4:0]           a3;
        logic                 bd;
        logic [4:0]           exc;
        logic [NLANES*DW-1:0] lanes;
    } beat_t;

    // A bubble keeps only the PC; every other field reads as zero.
    function automatic beat_t bubble(input logic [31:0] pc);
        beat_t b;
        b    = '0;
        b.pc = pc;
        return b;
    endfunction

    beat_t in_beat, out_q, skid_q;
    logic  out_valid_q, skid_valid;
    logic  in_fire, out_load;

    assign in_beat = '{pc: in_pc, instr: in_instr, a3: in_a3, bd: in_bd,
                       exc: in_exc, lanes: in_lanes};

    // With a skid the upstream only needs to know whether the spare slot is
    // free; without one, ready must look through to the downstream.
    assign in_ready = (SKID != 0) ? !skid_valid : (out_ready || !out_valid_q);
    assign in_fire  = in_valid && in_ready;
    // Output register may take a new value: empty or draining this edge.
    assign out_load = !out_valid_q || out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_q       <= bubble(RESET_PC);
            skid_valid  <= 1'b0;
            skid_q      <= '0;
        end else if (req) begin
            out_valid_q <= 1'b0;
            out_q       <= bubble(HANDLER_PC);
            skid_valid  <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
            out_q       <= bubble(out_q.pc);
            skid_valid  <= 1'b0;
        end else if (out_load) begin
            // Skid beat is older than anything on the input, so it goes first.
            // in_ready is low while the skid is full, so no input is lost here.
            if (skid_valid) begin
                out_valid_q <= 1'b1;
                out_q       <= skid_q;
                skid_valid  <= 1'b0;
            end else if (in_fire) begin
                out_valid_q <= 1'b1;
                out_q       <= in_beat;
            end else begin
                out_valid_q <= 1'b0;
                out_q       <= bubble(out_q.pc);
            end
        end else if (in_fire && SKID != 0) begin
            // Output stalled: park the accepted beat in the skid slot.
            skid_valid <= 1'b1;
            skid_q     <= in_beat;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pc    = out_q.pc;
    assign out_instr = out_q.instr;
    assign out_a3    = out_q.a3;
    assign out_bd    = out_q.bd;
    assign out_exc   = out_q.exc;
    assign out_lanes = out_q.lanes;

    // Counters sample the pre-edge handshake, including on req/flush cycles.
    logic stall_inc, kill_inc;
    assign stall_inc = out_valid_q && !out_ready;
    assign kill_inc  = req || flush;

    always_ff @(posedge clk) begin
        if (!reset || cnt_clr) begin
            stall_cnt <= '0;
            kill_cnt  <= '0;
        end else begin
            if (stall_inc && stall_cnt != '1) stall_cnt <= stall_cnt + CW'(1);
            if (kill_inc && kill_cnt != '1)   kill_cnt  <= kill_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: a vector table for the skid/stall,
// req and flush behaviour, then hand-written sequences for streaming order,
// counter saturation (CW=4, SKID=0 instance) and reset during a stall.
module tb_pipe_stage_elastic;

    logic        clk = 1'b0;
    logic        reset, req, flush, in_valid, out_ready, cnt_clr;
    logic [31:0] in_pc, in_instr;
    logic [4:0]  in_a3, in_exc;
    logic        in_bd;
    logic [95:0] in_lanes;

    logic        in_ready, out_valid, out_bd;
    logic [31:0] out_pc, out_instr;
    logic [4:0]  out_a3, out_exc;
    logic [95:0] out_lanes;
    logic [15:0] stall_cnt, kill_cnt;

    logic        in_ready4, out_valid4, out_bd4;
    logic [31:0] out_pc4, out_instr4;
    logic [4:0]  out_a34, out_exc4;
    logic [95:0] out_lanes4;
    logic [3:0]  stall_cnt4, kill_cnt4;

    always #5 clk = ~clk;

    pipe_stage_elastic dut (
        .clk(clk), .reset(reset), .req(req), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_instr(in_instr), .in_a3(in_a3), .in_bd(in_bd), .in_exc(in_exc),
        .in_lanes(in_lanes), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_a3(out_a3),
        .out_bd(out_bd), .out_exc(out_exc), .out_lanes(out_lanes),
        .cnt_clr(cnt_clr), .stall_cnt(stall_cnt), .kill_cnt(kill_cnt)
    );

    pipe_stage_elastic #(.SKID(0), .CW(4)) dut4 (
        .clk(clk), .reset(reset), .req(req), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready4), .in_pc(in_pc),
        .in_instr(in_instr), .in_a3(in_a3), .in_bd(in_bd), .in_exc(in_exc),
        .in_lanes(in_lanes), .out_valid(out_valid4), .out_ready(out_ready),
        .out_pc(out_pc4), .out_instr(out_instr4), .out_a3(out_a34),
        .out_bd(out_bd4), .out_exc(out_exc4), .out_lanes(out_lanes4),
        .cnt_clr(cnt_clr), .stall_cnt(stall_cnt4), .kill_cnt(kill_cnt4)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Payload derived from the PC so every field of a beat is recognisable.
    function automatic logic [31:0] f_instr(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction
    function automatic logic [95:0] f_lanes(input logic [31:0] pc);
        return {pc + 32'd2, pc + 32'd1, pc};
    endfunction

    task automatic drive_beat(input logic v, input logic [31:0] pc);
        in_valid = v;
        in_pc    = pc;
        in_instr = f_instr(pc);
        in_a3    = pc[6:2];
        in_bd    = pc[2];
        in_exc   = 5'h0C;
        in_lanes = f_lanes(pc);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Checks full payload: real beat fields when valid, zeros for a bubble.
    task automatic chk_payload(input string nm, input logic ev, input logic [31:0] epc);
        chk({nm, " out_valid"}, out_valid, ev);
        chk({nm, " out_pc"}, out_pc, epc);
        chk({nm, " out_instr"}, out_instr, ev ? f_instr(epc) : 32'h0);
        chk({nm, " out_a3"}, out_a3, ev ? epc[6:2] : 5'h0);
        chk({nm, " out_bd"}, out_bd, ev ? epc[2] : 1'b0);
        chk({nm, " out_exc"}, out_exc, ev ? 5'h0C : 5'h0);
        chk({nm, " out_lanes"}, out_lanes, ev ? f_lanes(epc) : 96'h0);
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic        ordy, rq, fl;
        logic        eov;
        logic [31:0] epc;
        logic        eir;
        int          est, ekl;
    } vec_t;

    vec_t tv[14];

    initial begin
        // iv  pc          ordy rq fl | ov  pc          ir  stall kill
        tv[0]  = '{1'b1, 32'h3100, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3100, 1'b1, 0, 0};
        tv[1]  = '{1'b1, 32'h3104, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3100, 1'b0, 1, 0};
        tv[2]  = '{1'b1, 32'h3108, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3100, 1'b0, 2, 0};
        tv[3]  = '{1'b1, 32'h3108, 1'b1, 1'b0, 1'b0, 1'b1, 32'h3104, 1'b1, 2, 0};
        tv[4]  = '{1'b1, 32'h3108, 1'b1, 1'b0, 1'b0, 1'b1, 32'h3108, 1'b1, 2, 0};
        tv[5]  = '{1'b0, 32'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h3108, 1'b1, 2, 0};
        tv[6]  = '{1'b1, 32'h3200, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3200, 1'b1, 2, 0};
        tv[7]  = '{1'b1, 32'h3204, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3200, 1'b0, 3, 0};
        tv[8]  = '{1'b1, 32'h3208, 1'b0, 1'b1, 1'b0, 1'b0, 32'h4180, 1'b1, 4, 1};
        tv[9]  = '{1'b1, 32'h3010, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3010, 1'b1, 4, 1};
        tv[10] = '{1'b0, 32'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h3010, 1'b1, 5, 2};
        tv[11] = '{1'b1, 32'h3014, 1'b1, 1'b0, 1'b0, 1'b1, 32'h3014, 1'b1, 5, 2};
        tv[12] = '{1'b1, 32'h3018, 1'b1, 1'b1, 1'b1, 1'b0, 32'h4180, 1'b1, 5, 3};
        tv[13] = '{1'b0, 32'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h4180, 1'b1, 5, 3};

        reset = 1'b0; req = 1'b0; flush = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
        drive_beat(1'b0, 32'h0);
        tick;
        tick;
        chk_payload("reset", 1'b0, 32'h3000);
        chk("reset in_ready", in_ready, 1'b1);
        chk("reset stall_cnt", stall_cnt, 16'h0);
        chk("reset kill_cnt", kill_cnt, 16'h0);
        chk("reset dut4 stall_cnt", stall_cnt4, 4'h0);
        chk("reset dut4 in_ready", in_ready4, 1'b1);

        reset = 1'b1;
        for (int i = 0; i < 14; i++) begin
            drive_beat(tv[i].iv, tv[i].pc);
            out_ready = tv[i].ordy;
            req       = tv[i].rq;
            flush     = tv[i].fl;
            tick;
            chk_payload($sformatf("vec%0d", i), tv[i].eov, tv[i].epc);
            chk($sformatf("vec%0d in_ready", i), in_ready, tv[i].eir);
            chk($sformatf("vec%0d stall_cnt", i), stall_cnt, 16'(tv[i].est));
            chk($sformatf("vec%0d kill_cnt", i), kill_cnt, 16'(tv[i].ekl));
        end
        req = 1'b0; flush = 1'b0;

        // Stream 8 beats with out_ready toggling 1010..; order and count checked.
        begin
            int idx = 0;
            int outcnt = 0;
            for (int cyc = 0; cyc < 60 && outcnt < 8; cyc++) begin
                out_ready = (cyc % 2 == 0);
                drive_beat(idx < 8, 32'h3000 + 32'(4 * idx));
                @(negedge clk);
                if (in_valid && in_ready) idx++;
                if (out_valid && out_ready) begin
                    chk($sformatf("stream beat%0d pc", outcnt), out_pc, 32'h3000 + 32'(4 * outcnt));
                    chk($sformatf("stream beat%0d lanes", outcnt), out_lanes,
                        f_lanes(32'h3000 + 32'(4 * outcnt)));
                    outcnt++;
                end
                @(posedge clk);
                #1;
            end
            chk("stream beats out", 32'(outcnt), 32'd8);
            chk("stream beats in", 32'(idx), 32'd8);
        end

        // Counter saturation: CW=4 instance must stick at 15.
        drive_beat(1'b0, 32'h0);
        out_ready = 1'b1;
        cnt_clr = 1'b1;
        tick;
        cnt_clr = 1'b0;
        out_ready = 1'b0;
        drive_beat(1'b1, 32'h3300);
        tick;
        drive_beat(1'b0, 32'h0);
        for (int i = 0; i < 20; i++) tick;
        chk("sat dut4 stall_cnt", stall_cnt4, 4'hF);
        chk("sat dut stall_cnt", stall_cnt, 16'd20);
        chk("sat dut4 out_pc", out_pc4, 32'h3300);
        cnt_clr = 1'b1;
        tick;
        cnt_clr = 1'b0;
        chk("clr dut4 stall_cnt", stall_cnt4, 4'h0);
        chk("clr dut stall_cnt", stall_cnt, 16'h0);
        chk("clr dut kill_cnt", kill_cnt, 16'h0);

        // Reset while stalled with the skid full: both beats must vanish.
        drive_beat(1'b1, 32'h3304);
        tick;
        chk("prefill in_ready", in_ready, 1'b0);
        drive_beat(1'b0, 32'h0);
        reset = 1'b0;
        tick;
        chk_payload("midreset", 1'b0, 32'h3000);
        chk("midreset in_ready", in_ready, 1'b1);
        chk("midreset dut4 in_ready", in_ready4, 1'b1);
        chk("midreset stall_cnt", stall_cnt, 16'h0);
        reset = 1'b1;
        out_ready = 1'b1;
        drive_beat(1'b1, 32'h3308);
        tick;
        chk_payload("postreset", 1'b1, 32'h3308);
        drive_beat(1'b0, 32'h0);
        tick;
        chk("postreset drained", out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
